serving_ram_sched: RTL and testbench
====================================

# serving_ram_sched

Word-to-byte access scheduler between the two 32-bit Wishbone requesters of the serving SoC (CPU instruction bus and data bus) and the byte-wide single-port-per-direction SoC SRAM. It arbitrates one requester at a time and splits each 32-bit access into four sequential byte accesses, little-endian. On a read it assembles the word from the SRAM's one-cycle registered read data. On a write it drives per-byte write enables from the byte selects.

## Interface
Parameters:
- `depth`, 256: SRAM size in bytes; must be a multiple of 4.
- `aw`, `$clog2(depth)`: byte address width.

Ports:
- `i_clk` in 1: clock; all state is updated on the rising edge.
- `i_rst` in 1: reset; asynchronous, active-high.
- `i_ibus_adr` in aw: instruction byte address; bits [1:0] ignored.
- `i_ibus_cyc` in 1: instruction read request.
- `o_ibus_rdt` out 32: instruction read data.
- `o_ibus_ack` out 1: instruction access done, one-cycle pulse.
- `i_dbus_adr` in aw: data byte address; bits [1:0] ignored.
- `i_dbus_dat` in 32: write data.
- `i_dbus_sel` in 4: byte selects; bit k selects byte k.
- `i_dbus_we` in 1: 1 = write, 0 = read.
- `i_dbus_cyc` in 1: data request.
- `o_dbus_rdt` out 32: data read data.
- `o_dbus_ack` out 1: data access done, one-cycle pulse.
- `o_waddr` out aw: SRAM write address.
- `o_wdata` out 8: SRAM write data.
- `o_wen` out 1: SRAM write enable.
- `o_raddr` out aw: SRAM read address.
- `i_rdata` in 8: SRAM read data; valid one cycle after `o_raddr`.

## Operation
- FSM states:
  - IDLE: sample requests, grant, latch the granted bus's address, write data, select bits and direction.
  - RUN: 2-bit byte counter `cnt` runs 0..3.
  - LAST: read only; capture byte 3.
  - ACK: pulse the granted ack.
- Transitions:
  - IDLE→RUN when any `cyc` is high.
  - RUN→RUN while `cnt`<3.
  - RUN(`cnt`=3)→LAST on a read.
  - RUN(`cnt`=3)→ACK on a write.
  - LAST→ACK.
  - ACK→IDLE, always.
- The ibus is always a read.
- RUN address: `{adr[aw-1:2], cnt}`, driven on `o_raddr` (read) or `o_waddr` (write).
- Write in RUN: `o_wdata` = `dat[8*cnt+7:8*cnt]`, `o_wen` = `sel[cnt]`. `sel`=0000 performs no writes but still acks.
- Read: `i_rdata` in the cycle after address `cnt`=k is captured into byte k of the shared 32-bit `rdt` register. `o_ibus_rdt` and `o_dbus_rdt` both drive `rdt`, which writes never modify.
- RAM-side outputs are decoded combinationally from the registers. Outside RUN, `o_raddr`, `o_waddr`, `o_wdata` and `o_wen` are 0.
- A started access always completes all four bytes and is acked, even if `cyc` drops mid-access; there is no abort.
- Requesters hold `cyc`, address and data until ack and drop `cyc` the cycle after ack. Because ACK→IDLE, the same request cannot be re-granted off a stale `cyc`.
- Reset values: state IDLE, `cnt` 0, `rdt` 0, both acks 0, `o_wen` 0, all addresses and `o_wdata` 0. Reset asserted mid-access clears everything immediately and asynchronously: `o_wen` drops in the same cycle, the remaining bytes are not written, and no ack is issued.

## Timing
- Cycle 0 is the cycle in which IDLE sees `cyc`.
- Read: addresses in cycles 1-4, bytes captured at the ends of cycles 2-5, ack high in cycle 6 with `rdt` final. Latency is 6 cycles; throughput is one read per 7 cycles.
- Write: `o_wen`/`o_waddr` in cycles 1-4, ack in cycle 5, next grant possible in cycle 7 (IDLE in cycle 6).
- Ack is high for exactly one cycle. `rdt` holds its value until the next read's first capture.

## Configuration
- `SERVING_RAM_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant register, reset to ibus, is updated on every grant.
  - On simultaneous `cyc`, the bus not granted last wins.
- `SERVING_RAM_RR_EN` undefined: fixed priority, dbus wins on simultaneous `cyc`; no last-grant register.

## Test plan
- dbus write, adr 0x10, dat 0xA1B2C3D4, sel 1111 → `o_wen`=1 in cycles 1-4 with `o_waddr` 0x10/0x11/0x12/0x13 and `o_wdata` D4/C3/B2/A1; `o_dbus_ack` in cycle 5 only.
- ibus read, adr 0x12, after the write above → `o_raddr` 0x10..0x13 in cycles 1-4; `o_ibus_ack` in cycle 6 with `o_ibus_rdt`=0xA1B2C3D4.
- dbus write, adr 0x10, dat 0x11223344, sel 0101 → `o_wen` only in cycles 1 and 3; a dbus read of 0x10 then returns 0xA122C344.
- ibus and dbus `cyc` raised in the same cycle, held until ack, then re-raised, twice:
  - without the macro: dbus is served both times before ibus;
  - with `SERVING_RAM_RR_EN`: grants alternate dbus, ibus, dbus, ibus.
- `i_rst` pulsed during cycle 2 of a sel 1111 write to 0x20:
  - `o_wen` is 0 during reset and no ack follows;
  - after reset, bytes 0x22/0x23 hold their prior values;
  - outputs equal their reset values.
- `i_dbus_cyc` dropped in cycle 2 of a read → access still completes and `o_dbus_ack` pulses in cycle 6; FSM back in IDLE in cycle 7.

Source files
------------

// File: rtl/serving_ram_sched.sv
// serving_ram_sched: arbitrates the ibus/dbus 32-bit Wishbone requesters onto a byte-wide SRAM,
// splitting each word access into four little-endian byte accesses. `SERVING_RAM_RR_EN enables round-robin.
module serving_ram_sched #(
  parameter int unsigned depth = 256,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [aw-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [aw-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [aw-1:0] o_raddr,
  input  logic [7:0]    i_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_ACK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [aw-3:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          gnt_dbus_q, gnt_dbus_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          ibus_ack_q, ibus_ack_d;
  logic          dbus_ack_q, dbus_ack_d;
  logic          pick_dbus;
  logic [1:0]    cap_idx;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

`ifdef SERVING_RAM_RR_EN
  logic last_dbus_q, last_dbus_d;

  // On contention the bus that did not win the previous grant goes first
  always_comb begin
    if (i_ibus_cyc && i_dbus_cyc) pick_dbus = ~last_dbus_q;
    else                          pick_dbus = i_dbus_cyc;
    last_dbus_d = last_dbus_q;
    if (state_q == S_IDLE && (i_ibus_cyc || i_dbus_cyc)) last_dbus_d = pick_dbus;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) last_dbus_q <= 1'b0;
    else       last_dbus_q <= last_dbus_d;
  end
`else
  assign pick_dbus = i_dbus_cyc;
`endif

  // Read data from address cnt-1 arrives while cnt is on the bus
  assign cap_idx = cnt_q - 2'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    gnt_dbus_d = gnt_dbus_q;
    rdt_d      = rdt_q;
    ibus_ack_d = 1'b0;
    dbus_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_ibus_cyc || i_dbus_cyc) begin
          state_d    = S_RUN;
          cnt_d      = 2'd0;
          gnt_dbus_d = pick_dbus;
          if (pick_dbus) begin
            adr_d = i_dbus_adr[aw-1:2];
            dat_d = i_dbus_dat;
            sel_d = i_dbus_sel;
            we_d  = i_dbus_we;
          end else begin
            adr_d = i_ibus_adr[aw-1:2];
            dat_d = '0;
            sel_d = '0;
            we_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (!we_q && cnt_q != 2'd0) rdt_d[{cap_idx, 3'b000} +: 8] = i_rdata;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (we_q) begin
            state_d    = S_ACK;
            ibus_ack_d = ~gnt_dbus_q;
            dbus_ack_d = gnt_dbus_q;
          end else begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        rdt_d[31:24] = i_rdata;
        state_d      = S_ACK;
        ibus_ack_d   = ~gnt_dbus_q;
        dbus_ack_d   = gnt_dbus_q;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      gnt_dbus_q <= 1'b0;
      rdt_q      <= '0;
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      gnt_dbus_q <= gnt_dbus_d;
      rdt_q      <= rdt_d;
      ibus_ack_q <= ibus_ack_d;
      dbus_ack_q <= dbus_ack_d;
    end
  end

  // SRAM side is a pure decode of the current byte slot; quiet outside RUN
  always_comb begin
    o_raddr = '0;
    o_waddr = '0;
    o_wdata = '0;
    o_wen   = 1'b0;
    if (state_q == S_RUN) begin
      if (we_q) begin
        o_waddr = {adr_q, cnt_q};
        o_wdata = dat_q[{cnt_q, 3'b000} +: 8];
        o_wen   = sel_q[cnt_q];
      end else begin
        o_raddr = {adr_q, cnt_q};
      end
    end
  end

  assign o_ibus_rdt = rdt_q;
  assign o_dbus_rdt = rdt_q;
  assign o_ibus_ack = ibus_ack_q;
  assign o_dbus_ack = dbus_ack_q;

endmodule

// File: tb/tb_serving_ram_sched.sv
// Testbench for serving_ram_sched: byte SRAM model plus a word-level reference memory.
`timescale 1ns/1ps
module tb_serving_ram_sched;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;
  logic [AW-1:0] i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_cyc;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;
  logic [AW-1:0] o_waddr;
  logic [7:0]    o_wdata;
  logic          o_wen;
  logic [AW-1:0] o_raddr;
  logic [7:0]    i_rdata;

  int checks = 0;
  int errors = 0;

  serving_ram_sched #(.depth(DEPTH), .aw(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen), .o_raddr(o_raddr), .i_rdata(i_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte SRAM with registered read data
  logic [7:0] sram [DEPTH];
  always @(posedge clk) begin
    if (o_wen) sram[o_waddr] <= o_wdata;
    i_rdata <= sram[o_raddr];
  end

  // Word-level reference memory
  logic [7:0] ref_mem [DEPTH];

  function automatic void ref_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[{adr[7:2], 2'(b)}] = dat[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [7:0] adr);
    logic [5:0] a;
    a = adr[7:2];
    return {ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}], ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]};
  endfunction

  // Per-cycle observations of the last access, index = cycle number after the request cycle
  logic       obs_wen   [8];
  logic [7:0] obs_waddr [8];
  logic [7:0] obs_wdata [8];
  logic [7:0] obs_raddr [8];
  logic       obs_iack  [8];
  logic       obs_dack  [8];
  logic [31:0] obs_irdt, obs_drdt;

  task automatic access(input bit use_d, input bit we, input logic [7:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int drop_at);
    obs_irdt = 'x;
    obs_drdt = 'x;
    @(negedge clk);
    if (use_d) begin
      i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we; i_dbus_cyc = 1'b1;
    end else begin
      i_ibus_adr = adr; i_ibus_cyc = 1'b1;
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      obs_wen[k] = o_wen; obs_waddr[k] = o_waddr; obs_wdata[k] = o_wdata;
      obs_raddr[k] = o_raddr; obs_iack[k] = o_ibus_ack; obs_dack[k] = o_dbus_ack;
      if (o_ibus_ack) obs_irdt = o_ibus_rdt;
      if (o_dbus_ack) obs_drdt = o_dbus_rdt;
      if (k == drop_at || o_ibus_ack || o_dbus_ack) begin
        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
      end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    if (use_d && we) ref_write(adr, dat, sel);
  endtask

  task automatic test_reset();
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", o_wen); end
    checks++; if (o_waddr !== 8'h00 || o_raddr !== 8'h00 || o_wdata !== 8'h00) begin
      errors++; $display("FAIL rst_addr got waddr %h raddr %h wdata %h exp 00", o_waddr, o_raddr, o_wdata); end
    checks++; if (o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0) begin
      errors++; $display("FAIL rst_ack got %b%b exp 00", o_ibus_ack, o_dbus_ack); end
    checks++; if (o_ibus_rdt !== 32'h0 || o_dbus_rdt !== 32'h0) begin
      errors++; $display("FAIL rst_rdt got %h/%h exp 0", o_ibus_rdt, o_dbus_rdt); end
  endtask

  task automatic test_write_basic();
    logic [31:0] dat;
    dat = 32'hA1B2C3D4;
    access(1'b1, 1'b1, 8'h10, dat, 4'b1111, 0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({obs_wen[k], obs_waddr[k], obs_wdata[k]} !== {1'b1, 8'(8'h10 + k - 1), 8'(dat >> (8 * (k - 1)))}) begin
        errors++;
        $display("FAIL wr_basic_c%0d got wen %b adr %h dat %h exp wen 1 adr %h dat %h", k,
                 obs_wen[k], obs_waddr[k], obs_wdata[k], 8'(8'h10 + k - 1), 8'(dat >> (8 * (k - 1))));
      end
    end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs_dack[k] !== (k == 5) || obs_iack[k] !== 1'b0) begin
        errors++; $display("FAIL wr_basic_ack_c%0d got d%b i%b exp d%0d i0", k, obs_dack[k], obs_iack[k], k == 5);
      end
    end
  endtask

  task automatic test_read_ibus();
    access(1'b0, 1'b0, 8'h12, 32'h0, 4'h0, 0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs_raddr[k] !== 8'(8'h10 + k - 1)) begin
        errors++; $display("FAIL rd_ibus_raddr_c%0d got %h exp %h", k, obs_raddr[k], 8'(8'h10 + k - 1));
      end
    end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs_iack[k] !== (k == 6) || obs_dack[k] !== 1'b0) begin
        errors++; $display("FAIL rd_ibus_ack_c%0d got i%b d%b exp i%0d d0", k, obs_iack[k], obs_dack[k], k == 6);
      end
    end
    checks++; if (obs_irdt !== 32'hA1B2C3D4 || obs_irdt !== ref_read(8'h12)) begin
      errors++; $display("FAIL rd_ibus_data got %h exp %h", obs_irdt, 32'hA1B2C3D4); end
    checks++; if (o_dbus_rdt !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL rd_shared_rdt got %h exp %h", o_dbus_rdt, 32'hA1B2C3D4); end
  endtask

  task automatic test_partial_write();
    logic [3:0] sel;
    sel = 4'b0101;
    access(1'b1, 1'b1, 8'h10, 32'h11223344, sel, 0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs_wen[k] !== sel[k-1]) begin
        errors++; $display("FAIL pw_wen_c%0d got %b exp %b", k, obs_wen[k], sel[k-1]);
      end
    end
    checks++; if (o_ibus_rdt !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL pw_rdt_kept got %h exp %h", o_ibus_rdt, 32'hA1B2C3D4); end
    access(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 0);
    checks++; if (obs_drdt !== 32'hA122C344 || obs_drdt !== ref_read(8'h10)) begin
      errors++; $display("FAIL pw_readback got %h exp %h", obs_drdt, 32'hA122C344); end
  endtask

  task automatic test_arbitration();
    int order[$];
    int exp_order[4];
    int rem_i, rem_d;
`ifdef SERVING_RAM_RR_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 0, 0};
`endif
    rem_i = 2; rem_d = 2;
    @(negedge clk);
    i_ibus_adr = 8'h10; i_dbus_adr = 8'h12; i_dbus_we = 1'b0; i_dbus_sel = 4'hF;
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    for (int c = 0; c < 80 && (rem_i > 0 || rem_d > 0); c++) begin
      @(negedge clk);
      if (o_dbus_ack) begin
        order.push_back(1); rem_d--;
        if (rem_d == 0) i_dbus_cyc = 1'b0;
        checks++; if (o_dbus_rdt !== ref_read(8'h12)) begin
          errors++; $display("FAIL arb_drdt got %h exp %h", o_dbus_rdt, ref_read(8'h12)); end
      end
      if (o_ibus_ack) begin
        order.push_back(0); rem_i--;
        if (rem_i == 0) i_ibus_cyc = 1'b0;
      end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    checks++; if (rem_i != 0 || rem_d != 0) begin
      errors++; $display("FAIL arb_timeout got remaining i%0d d%0d exp 0 0", rem_i, rem_d); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= order.size()) begin
        errors++; $display("FAIL arb_order_%0d got none exp %0d", i, exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        errors++; $display("FAIL arb_order_%0d got %0d exp %0d (1=dbus)", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    access(1'b1, 1'b1, 8'h20, 32'h55667788, 4'b1111, 0);
    @(negedge clk);
    i_dbus_adr = 8'h20; i_dbus_dat = 32'hDEADBEEF; i_dbus_sel = 4'b1111; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    @(negedge clk);
    checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL mr_wen_c1 got %b exp 1", o_wen); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL mr_wen_in_rst got %b exp 0", o_wen); end
    i_dbus_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (o_wen !== 1'b0 || o_waddr !== 8'h00 || o_raddr !== 8'h00 || o_wdata !== 8'h00) begin
      errors++; $display("FAIL mr_outs got wen %b waddr %h raddr %h wdata %h exp 0", o_wen, o_waddr, o_raddr, o_wdata); end
    checks++; if (o_dbus_rdt !== 32'h0 || o_ibus_rdt !== 32'h0) begin
      errors++; $display("FAIL mr_rdt got %h exp 0", o_dbus_rdt); end
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_dbus_ack || o_ibus_ack) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL mr_no_ack got %0d acks exp 0", acks); end
    ref_mem[8'h20] = 8'hEF;
    access(1'b1, 1'b0, 8'h20, 32'h0, 4'h0, 0);
    checks++; if (obs_drdt[31:16] !== 16'h5566 || obs_drdt[7:0] !== 8'hEF) begin
      errors++; $display("FAIL mr_mem got %h exp 5566xxEF", obs_drdt); end
    access(1'b1, 1'b1, 8'h20, $urandom, 4'b1111, 0);
  endtask

  task automatic test_cyc_drop();
    access(1'b1, 1'b1, 8'h14, $urandom, 4'b1111, 0);
    access(1'b1, 1'b0, 8'h14, 32'h0, 4'h0, 1);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs_dack[k] !== (k == 6)) begin
        errors++; $display("FAIL drop_ack_c%0d got %b exp %0d", k, obs_dack[k], k == 6);
      end
    end
    checks++; if (obs_drdt !== ref_read(8'h14)) begin
      errors++; $display("FAIL drop_data got %h exp %h", obs_drdt, ref_read(8'h14)); end
    // Request raised in cycle 7 must be granted straight away
    i_ibus_adr = 8'h18; i_ibus_cyc = 1'b1;
    @(negedge clk);
    checks++; if (o_raddr !== 8'h18) begin
      errors++; $display("FAIL drop_idle_c7 got raddr %h exp 18", o_raddr); end
    for (int k = 0; k < 10 && !o_ibus_ack; k++) @(negedge clk);
    checks++; if (o_ibus_ack !== 1'b1 || o_ibus_rdt !== ref_read(8'h18)) begin
      errors++; $display("FAIL drop_next got ack %b rdt %h exp 1 %h", o_ibus_ack, o_ibus_rdt, ref_read(8'h18)); end
    i_ibus_cyc = 1'b0;
  endtask

  task automatic test_random();
    bit          use_d, we;
    logic [7:0]  adr;
    logic [31:0] dat, exp;
    logic [3:0]  sel;
    for (int n = 0; n < 40; n++) begin
      use_d = 1'($urandom_range(0, 1));
      we    = use_d ? 1'($urandom_range(0, 1)) : 1'b0;
      adr   = 8'($urandom);
      dat   = $urandom;
      sel   = 4'($urandom);
      exp   = ref_read(adr);
      access(use_d, we, adr, dat, sel, 0);
      if (we) begin
        for (int k = 1; k <= 4; k++) begin
          checks++;
          if ({obs_wen[k], obs_waddr[k], obs_wdata[k]} !==
              {sel[k-1], adr[7:2], 2'(k - 1), 8'(dat >> (8 * (k - 1)))}) begin
            errors++;
            $display("FAIL rnd%0d_wr_c%0d got wen %b adr %h dat %h exp wen %b adr %h dat %h", n, k,
                     obs_wen[k], obs_waddr[k], obs_wdata[k], sel[k-1], {adr[7:2], 2'(k - 1)}, 8'(dat >> (8 * (k - 1))));
          end
        end
        checks++;
        if (obs_dack[5] !== 1'b1 || obs_dack[4] !== 1'b0 || obs_dack[6] !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_wr_ack got c4..6 %b%b%b exp 010", n, obs_dack[4], obs_dack[5], obs_dack[6]);
        end
      end else begin
        checks++;
        if ((use_d ? obs_dack[6] : obs_iack[6]) !== 1'b1 || (use_d ? obs_dack[5] : obs_iack[5]) !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_rd_ack got c5 %b c6 %b exp 0 1", n,
                             use_d ? obs_dack[5] : obs_iack[5], use_d ? obs_dack[6] : obs_iack[6]);
        end
        checks++;
        if ((use_d ? obs_drdt : obs_irdt) !== exp) begin
          errors++; $display("FAIL rnd%0d_rd_data adr %h got %h exp %h", n, adr, use_d ? obs_drdt : obs_irdt, exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write_basic();
    test_read_ibus();
    test_partial_write();
    test_arbitration();
    test_reset_mid_write();
    test_cyc_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
